// File: rtl/trg_src_arbiter.sv
// Trigger source arbiter: merges three trigger request sources into a single
// active-low DAQ trigger, followed by a dead time and a wait for DAQ ready.
module trg_src_arbiter #(
    parameter int TRG_PULSE_W = 5,
    parameter int DEAD_UNIT   = 50
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        coincid_trg_in,
    input  logic        ext_trg_syn_in,
    input  logic        cycled_trg_in,
    input  logic [2:0]  src_enb_in,
    input  logic        trg_enb_in,
    input  logic [7:0]  trg_dead_time_in,
    input  logic        daq_busy_in,
    input  logic        cnt_clr_in,
    output logic        trg_out_N,
    output logic        eff_trg_out,
    output logic [2:0]  trg_src_tag_out,
    output logic        daq_busy_out,
    output logic [15:0] eff_trg_cnt_out,
    output logic [15:0] lost_trg_cnt_out
);

    typedef enum logic [1:0] {IDLE, FIRE, DEAD, WAIT_BUSY} state_t;

    // Dead counter must hold 255 * DEAD_UNIT and is never narrower than 14 bits
    localparam int DEAD_MAX = 255 * DEAD_UNIT;
    localparam int DEAD_CW  = ($clog2(DEAD_MAX + 1) > 14) ? $clog2(DEAD_MAX + 1) : 14;

    state_t               state;
    state_t               next_state;
    logic [3:0]           pulse_cnt;
    logic [7:0]           dead_lat;
    logic [DEAD_CW-1:0]   dead_cnt;
    logic [DEAD_CW-1:0]   dead_total;
    logic [2:0]           req;
    logic                 hit;
    logic                 grant;
    logic                 lost_hit;
    logic                 pulse_done;
    logic                 dead_done;
    logic                 trg_n_d;
    logic                 busy_d;

    assign req        = {coincid_trg_in, ext_trg_syn_in, cycled_trg_in} & src_enb_in;
    assign hit        = trg_enb_in & (|req);
    assign pulse_done = (pulse_cnt == 4'(TRG_PULSE_W - 1));
    assign dead_done  = (dead_cnt == '0);
    assign dead_total = DEAD_CW'(dead_lat) * DEAD_CW'(DEAD_UNIT);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (hit) next_state = FIRE;
            FIRE:      if (pulse_done) next_state = (dead_lat == 8'd0) ? WAIT_BUSY : DEAD;
            DEAD:      if (dead_done) next_state = WAIT_BUSY;
            WAIT_BUSY: if (!daq_busy_in) next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    // Outputs are computed from the next state so their registers switch with the state
    always_comb begin
        trg_n_d  = (next_state != FIRE);
        busy_d   = (next_state != IDLE);
        grant    = (state == IDLE) && hit;
        lost_hit = (state != IDLE) && hit;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            trg_out_N       <= 1'b1;
            daq_busy_out    <= 1'b0;
            eff_trg_out     <= 1'b0;
            trg_src_tag_out <= 3'b000;
            dead_lat        <= 8'd0;
        end else begin
            trg_out_N    <= trg_n_d;
            daq_busy_out <= busy_d;
            eff_trg_out  <= grant;
            if (grant) begin
                trg_src_tag_out <= req;
                dead_lat        <= trg_dead_time_in;
            end
        end
    end

    // Dead counter is loaded with total-1 so DEAD lasts exactly the programmed cycles
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pulse_cnt <= 4'd0;
            dead_cnt  <= '0;
        end else begin
            if (state == FIRE) pulse_cnt <= pulse_cnt + 4'd1;
            else               pulse_cnt <= 4'd0;
            if (state == FIRE && next_state == DEAD) dead_cnt <= dead_total - 1'b1;
            else if (state == DEAD && !dead_done)    dead_cnt <= dead_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            eff_trg_cnt_out  <= 16'd0;
            lost_trg_cnt_out <= 16'd0;
        end else if (cnt_clr_in) begin
            eff_trg_cnt_out  <= 16'd0;
            lost_trg_cnt_out <= 16'd0;
        end else begin
            if (grant && eff_trg_cnt_out != 16'hFFFF)
                eff_trg_cnt_out <= eff_trg_cnt_out + 16'd1;
            if (lost_hit && lost_trg_cnt_out != 16'hFFFF)
                lost_trg_cnt_out <= lost_trg_cnt_out + 16'd1;
        end
    end

endmodule

// File: tb/tb_trg_src_arbiter.sv
// Self-checking bench for trg_src_arbiter: grants are scoreboarded by tag and
// count, timing and lost-request behaviour are checked against fixed values.
module tb_trg_src_arbiter;

    logic        clk_in;
    logic        rst_in;
    logic        coincid_trg_in;
    logic        ext_trg_syn_in;
    logic        cycled_trg_in;
    logic [2:0]  src_enb_in;
    logic        trg_enb_in;
    logic [7:0]  trg_dead_time_in;
    logic        daq_busy_in;
    logic        cnt_clr_in;
    logic        trg_out_N;
    logic        eff_trg_out;
    logic [2:0]  trg_src_tag_out;
    logic        daq_busy_out;
    logic [15:0] eff_trg_cnt_out;
    logic [15:0] lost_trg_cnt_out;

    typedef struct packed {
        logic [2:0]  tag;
        logic [15:0] cnt;
    } sb_entry_t;

    sb_entry_t   sb_q[$];
    sb_entry_t   sb_e;
    int          total = 0;
    int          bad   = 0;
    int          hold_cycles;
    logic [15:0] exp_eff  = 16'd0;
    logic [15:0] exp_lost = 16'd0;

    trg_src_arbiter #(.TRG_PULSE_W(5), .DEAD_UNIT(50)) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .coincid_trg_in   (coincid_trg_in),
        .ext_trg_syn_in   (ext_trg_syn_in),
        .cycled_trg_in    (cycled_trg_in),
        .src_enb_in       (src_enb_in),
        .trg_enb_in       (trg_enb_in),
        .trg_dead_time_in (trg_dead_time_in),
        .daq_busy_in      (daq_busy_in),
        .cnt_clr_in       (cnt_clr_in),
        .trg_out_N        (trg_out_N),
        .eff_trg_out      (eff_trg_out),
        .trg_src_tag_out  (trg_src_tag_out),
        .daq_busy_out     (daq_busy_out),
        .eff_trg_cnt_out  (eff_trg_cnt_out),
        .lost_trg_cnt_out (lost_trg_cnt_out)
    );

    initial clk_in = 1'b0;
    always #10 clk_in = ~clk_in;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk_in);
    endtask

    // Drives one request pulse that must be granted and queues the expected grant
    task automatic applyStimulus(input logic [2:0] pulse);
        exp_eff = cnt_clr_in ? 16'd0 : exp_eff + 16'd1;
        sb_q.push_back('{tag: pulse & src_enb_in, cnt: exp_eff});
        {coincid_trg_in, ext_trg_syn_in, cycled_trg_in} = pulse;
        tick();
        {coincid_trg_in, ext_trg_syn_in, cycled_trg_in} = 3'b000;
        cnt_clr_in = 1'b0;
    endtask

    task automatic waitIdle(input string tag);
        int n = 0;
        while (daq_busy_out && n < 20000) begin
            tick();
            n++;
        end
        checkOutput(tag, daq_busy_out, 0);
    endtask

    always @(negedge clk_in) begin
        if (!rst_in && eff_trg_out) begin
            if (sb_q.size() == 0) begin
                checkOutput("sb_unexpected_grant", eff_trg_out, 0);
            end else begin
                sb_e = sb_q.pop_front();
                checkOutput("sb_tag", trg_src_tag_out, sb_e.tag);
                checkOutput("sb_eff_cnt", eff_trg_cnt_out, sb_e.cnt);
            end
        end
    end

    initial begin
        rst_in = 1'b1;
        {coincid_trg_in, ext_trg_syn_in, cycled_trg_in} = 3'b000;
        src_enb_in       = 3'b111;
        trg_enb_in       = 1'b1;
        trg_dead_time_in = 8'd0;
        daq_busy_in      = 1'b0;
        cnt_clr_in       = 1'b0;
        repeat (3) tick();

        checkOutput("rst_trg_n", trg_out_N, 1);
        checkOutput("rst_eff", eff_trg_out, 0);
        checkOutput("rst_tag", trg_src_tag_out, 0);
        checkOutput("rst_busy", daq_busy_out, 0);
        checkOutput("rst_eff_cnt", eff_trg_cnt_out, 0);
        checkOutput("rst_lost_cnt", lost_trg_cnt_out, 0);

        rst_in = 1'b0;
        repeat (9) tick();

        // Grant timing with dead=2; dead time and busy wiggle mid-sequence must not matter
        trg_dead_time_in = 8'd2;
        applyStimulus(3'b100);
        for (int c = 11; c <= 117; c++) begin
            checkOutput("timing_trg_n", trg_out_N, (c <= 15) ? 0 : 1);
            checkOutput("timing_busy", daq_busy_out, (c <= 116) ? 1 : 0);
            if (c == 12) begin
                checkOutput("timing_eff_one_cycle", eff_trg_out, 0);
                trg_dead_time_in = 8'd7;
            end
            if (c == 14) daq_busy_in = 1'b1;
            if (c == 60) daq_busy_in = 1'b0;
            tick();
        end

        trg_dead_time_in = 8'd0;
        applyStimulus(3'b101);
        waitIdle("idle_simultaneous");
        checkOutput("lost_simultaneous", lost_trg_cnt_out, exp_lost);

        // Lost counting during DEAD, masked source and disabled trigger are not counted
        trg_dead_time_in = 8'd2;
        applyStimulus(3'b010);
        repeat (8) tick();
        ext_trg_syn_in = 1'b1;
        exp_lost = exp_lost + 16'd1;
        tick();
        ext_trg_syn_in = 1'b0;
        src_enb_in = 3'b110;
        cycled_trg_in = 1'b1;
        tick();
        cycled_trg_in = 1'b0;
        src_enb_in = 3'b111;
        trg_enb_in = 1'b0;
        coincid_trg_in = 1'b1;
        tick();
        coincid_trg_in = 1'b0;
        waitIdle("idle_enb_drop");
        trg_enb_in = 1'b1;
        checkOutput("lost_masked", lost_trg_cnt_out, exp_lost);

        trg_dead_time_in = 8'd0;
        daq_busy_in = 1'b1;
        applyStimulus(3'b001);
        for (int k = 0; k < 200; k++) begin
            checkOutput("wb_busy", daq_busy_out, 1);
            checkOutput("wb_trg_n", trg_out_N, (k < 5) ? 0 : 1);
            if (k == 199) daq_busy_in = 1'b0;
            tick();
        end
        checkOutput("wb_release_idle", daq_busy_out, 0);

        // Continuous requests while stuck in WAIT_BUSY drive the lost counter to saturation
        daq_busy_in = 1'b1;
        applyStimulus(3'b100);
        cycled_trg_in = 1'b1;
        hold_cycles = 32'h0000_FFFE - int'(exp_lost);
        repeat (hold_cycles) tick();
        exp_lost = 16'hFFFE;
        checkOutput("lost_preload", lost_trg_cnt_out, exp_lost);
        repeat (3) tick();
        exp_lost = 16'hFFFF;
        checkOutput("lost_saturate", lost_trg_cnt_out, exp_lost);
        cycled_trg_in = 1'b0;
        daq_busy_in = 1'b0;
        waitIdle("idle_saturate");

        cnt_clr_in = 1'b1;
        applyStimulus(3'b100);
        exp_lost = 16'd0;
        checkOutput("clr_lost", lost_trg_cnt_out, exp_lost);
        checkOutput("clr_eff", eff_trg_cnt_out, exp_eff);
        waitIdle("idle_clear");

        // Asynchronous reset between edges in the middle of the trigger pulse
        trg_dead_time_in = 8'd2;
        applyStimulus(3'b001);
        repeat (2) tick();
        #3 rst_in = 1'b1;
        #1;
        checkOutput("arst_trg_n", trg_out_N, 1);
        checkOutput("arst_busy", daq_busy_out, 0);
        checkOutput("arst_eff_cnt", eff_trg_cnt_out, 0);
        checkOutput("arst_tag", trg_src_tag_out, 0);
        tick();
        rst_in = 1'b0;
        exp_eff = 16'd0;
        exp_lost = 16'd0;
        tick();
        applyStimulus(3'b010);
        checkOutput("post_rst_trg_n", trg_out_N, 0);
        waitIdle("idle_post_rst");
        checkOutput("post_rst_lost", lost_trg_cnt_out, exp_lost);

        checkOutput("sb_pending", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/trg_src_arbiter.md
TRG_SRC_ARBITER -- requirements
Module: trg_src_arbiter

Interface
REQ-001 Parameter TRG_PULSE_W, default 5: trg_out_N low width in clk_in cycles (100 ns at 50 MHz); legal 1..15.
REQ-002 Parameter DEAD_UNIT, default 50: clk_in cycles per trg_dead_time_in LSB (1 us).
REQ-003 Port clk_in, input, 1: system clock, 50 MHz; the only clock.
REQ-004 Port rst_in, input, 1: reset, asynchronous, active-high.
REQ-005 Port coincid_trg_in, input, 1: coincidence trigger request, single-cycle pulse.
REQ-006 Port ext_trg_syn_in, input, 1: synchronised external trigger request, single-cycle pulse.
REQ-007 Port cycled_trg_in, input, 1: cycled (periodic) trigger request, single-cycle pulse.
REQ-008 Port src_enb_in, input, 3: per-source enable, bit2 = coincid, bit1 = ext, bit0 = cycled.
REQ-009 Port trg_enb_in, input, 1: global trigger enable.
REQ-010 Port trg_dead_time_in, input, 8: dead time in DEAD_UNIT ticks.
REQ-011 Port daq_busy_in, input, 1: downstream DAQ busy, active-high.
REQ-012 Port cnt_clr_in, input, 1: synchronous clear of both counters.
REQ-013 Port trg_out_N, output, 1: trigger to DAQ, active-low.
REQ-014 Port eff_trg_out, output, 1: one-cycle strobe per granted trigger.
REQ-015 Port trg_src_tag_out, output, 3: sources granted in the last grant, same bit order as src_enb_in.
REQ-016 Port daq_busy_out, output, 1: arbiter not ready for a new trigger.
REQ-017 Port eff_trg_cnt_out, output, 16: granted-trigger count.
REQ-018 Port lost_trg_cnt_out, output, 16: rejected-request count.

Function
REQ-019 req[2:0] SHALL be {coincid, ext, cycled} AND src_enb_in; a hit SHALL be trg_enb_in AND (req != 0).
REQ-020 The FSM SHALL have four states: IDLE, FIRE, DEAD and WAIT_BUSY.
REQ-021 IDLE with a hit in cycle N SHALL produce all of the following in cycle N+1:
  - state FIRE;
  - eff_trg_out = 1 for exactly one cycle;
  - trg_src_tag_out = req sampled in cycle N, held until the next grant;
  - eff_trg_cnt_out incremented;
  - trg_dead_time_in latched.
REQ-022 Simultaneous requests SHALL yield one grant whose tag has every requesting bit set; no second trigger SHALL be issued for them.
REQ-023 FIRE SHALL drive trg_out_N = 0 for exactly TRG_PULSE_W cycles.
REQ-024 On leaving FIRE, the FSM SHALL enter DEAD, or WAIT_BUSY when the latched dead time is 0.
REQ-025 DEAD SHALL last latched_dead_time * DEAD_UNIT cycles, counted by a counter of at least 14 bits, then enter WAIT_BUSY.
REQ-026 WAIT_BUSY SHALL enter IDLE in the cycle after daq_busy_in is sampled 0; with daq_busy_in already 0, it lasts one cycle.
REQ-027 daq_busy_out SHALL be 1 in every state except IDLE; it SHALL be registered and change in the same cycle as the state.
REQ-028 In any cycle with state != IDLE and a hit, lost_trg_cnt_out SHALL increment by 1, regardless of how many req bits are set; requests SHALL NOT be queued.
REQ-029 Both counters SHALL saturate at 16'hFFFF.
REQ-030 cnt_clr_in SHALL zero both counters next cycle and SHALL take priority over any increment in the same cycle.
REQ-031 A trg_enb_in or src_enb_in drop mid-sequence SHALL NOT abort the sequence; the in-progress pulse and dead time SHALL complete, and no new grant SHALL be issued.
REQ-032 trg_dead_time_in or DAQ-busy changes during FIRE or DEAD SHALL NOT alter the current sequence.

Reset
REQ-033 While rst_in = 1, the block SHALL hold: state IDLE, trg_out_N = 1, eff_trg_out = 0, trg_src_tag_out = 0, daq_busy_out = 0, both counters 0, dead counter 0.
REQ-034 rst_in asserted mid-FIRE or mid-DEAD SHALL force the REQ-033 values immediately, without waiting for a clock edge.
REQ-035 After rst_in is released, the first hit SHALL be granted normally.

Verification
REQ-036 Grant timing: src_enb = 3'b111, trg_enb = 1, dead = 2, daq_busy = 0, coincid pulse at cycle 10 -> all of the following:
  - eff_trg_out = 1 at cycle 11;
  - tag = 3'b100;
  - trg_out_N low in cycles 11..15;
  - daq_busy_out high 11..116;
  - IDLE at 117;
  - eff cnt = 1.
REQ-037 Simultaneous sources: coincid and cycled pulsed in the same cycle -> one grant, tag = 3'b101, eff cnt +1, lost cnt +0.
REQ-038 Lost counting: ext pulse during DEAD, and cycled pulse with src_enb = 3'b110 -> lost cnt = 1 (masked pulse not counted).
REQ-039 Dead time zero with DAQ busy: dead = 0, daq_busy_in held 1 for 200 cycles after grant -> WAIT_BUSY throughout, IDLE one cycle after release.
REQ-040 Counter saturation and clear: lost counter preloaded to 16'hFFFE, three lost requests -> 16'hFFFF; cnt_clr_in together with a grant -> eff cnt = 0.
REQ-041 Asynchronous reset mid-pulse: rst_in raised mid-pulse between clock edges -> trg_out_N = 1 and daq_busy_out = 0 before the next edge; grant works after release.
